// File: rtl/stopwatch_if.sv
// stopwatch_if: button, live-count and display/control signals between a stopwatch controller and its surroundings
interface stopwatch_if;
  logic btn_start_stop;
  logic btn_lap_clear;
  logic [9:0] mili_segundos;
  logic [9:0] segundos;
  logic cnt_enable;
  logic cnt_rst_n;
  logic [9:0] disp_ms;
  logic [9:0] disp_s;
  logic [1:0] state;
  logic running;
  modport master (
    output btn_start_stop, btn_lap_clear, mili_segundos, segundos,
    input cnt_enable, cnt_rst_n, disp_ms, disp_s, state, running
  );
  modport slave (
    input btn_start_stop, btn_lap_clear, mili_segundos, segundos,
    output cnt_enable, cnt_rst_n, disp_ms, disp_s, state, running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/clear FSM with ms prescaler and display latch; LAP freeze enabled by STOPWATCH_LAP_EN
module stopwatch_ctrl #(
  parameter int TICKS_PER_MS = 50000
) (
  input logic clk,
  input logic rst,
  stopwatch_if.slave sw
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3} state_t;
  localparam logic [19:0] LAST = 20'(TICKS_PER_MS - 1);
  state_t st, nxt;
  logic [2:0] ss_sync, lc_sync;
  logic [19:0] pre_cnt;
  logic rst_n_q;
  logic [9:0] ms_q, s_q;
  logic ss_press, lc_press, active, tick, freeze;
  // bits [1:0] synchronize, bit [2] is the previous synchronized level for edge detection
  assign ss_press = ss_sync[1] & ~ss_sync[2];
  assign lc_press = lc_sync[1] & ~lc_sync[2];
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = ss_press ? RUN : IDLE;
`ifdef STOPWATCH_LAP_EN
      RUN: nxt = ss_press ? PAUSE : lc_press ? LAP : RUN;
      LAP: nxt = ss_press ? PAUSE : lc_press ? RUN : LAP;
`else
      RUN: nxt = ss_press ? PAUSE : RUN;
`endif
      PAUSE: nxt = ss_press ? RUN : lc_press ? IDLE : PAUSE;
      default: nxt = IDLE;
    endcase
  end
  // counting only while staying in RUN/LAP keeps the leaving cycle tick-free and preserves the partial ms
  assign active = (st == RUN || st == LAP) && (nxt == RUN || nxt == LAP);
  assign tick = active && pre_cnt == LAST && !rst;
`ifdef STOPWATCH_LAP_EN
  assign freeze = st == LAP && nxt == LAP;
`else
  assign freeze = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync <= '1;
      lc_sync <= '1;
      st <= IDLE;
      pre_cnt <= '0;
      rst_n_q <= 1'b0;
      ms_q <= '0;
      s_q <= '0;
    end else begin
      ss_sync <= {ss_sync[1:0], sw.btn_start_stop};
      lc_sync <= {lc_sync[1:0], sw.btn_lap_clear};
      st <= nxt;
      pre_cnt <= (nxt == IDLE) ? '0 : !active ? pre_cnt : tick ? '0 : pre_cnt + 20'd1;
      rst_n_q <= !(st == PAUSE && nxt == IDLE);
      ms_q <= freeze ? ms_q : sw.mili_segundos;
      s_q <= freeze ? s_q : sw.segundos;
    end
  end
  assign sw.cnt_enable = tick;
  assign sw.cnt_rst_n = rst_n_q;
  assign sw.disp_ms = ms_q;
  assign sw.disp_s = s_q;
  assign sw.state = st;
  assign sw.running = st == RUN || st == LAP;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scenario tasks plus randomized run against a behavioural stopwatch model (TICKS_PER_MS=4)
module tb_stopwatch_ctrl;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  stopwatch_if sw();
  stopwatch_ctrl #(.TICKS_PER_MS(T)) dut (.clk(clk), .rst(rst), .sw(sw));
  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] m_state = 2'd0;
  logic [1:0] m_n = 2'd0;
  logic m_rstn = 1'b0;
  logic [9:0] m_ms = '0, m_s = '0;
  int m_active = 0;
  int m_base = 0;
  int obs_ticks = 0;
  logic [2:0] h_ss = '1, h_lc = '1;

  function automatic logic [1:0] next_of(input logic [1:0] s, input logic ssp, input logic lcp);
    logic [1:0] n;
    n = s;
    if (ssp) n = (s == 2'd1 || s == 2'd3) ? 2'd2 : 2'd1;
    else if (lcp && s == 2'd2) n = 2'd0;
`ifdef STOPWATCH_LAP_EN
    else if (lcp && s == 2'd1) n = 2'd3;
    else if (lcp && s == 2'd3) n = 2'd1;
`endif
    return n;
  endfunction
  function automatic logic running_of(input logic [1:0] s);
    return s == 2'd1 || s == 2'd3;
  endfunction
  function automatic logic [1:0] m_next();
    return next_of(m_state, h_ss[1] & ~h_ss[2], h_lc[1] & ~h_lc[2]);
  endfunction
  function automatic logic m_en();
    return !rst && running_of(m_state) && running_of(m_next()) && (m_active % T == T - 1);
  endfunction
  function automatic int m_ticks();
    return m_base + m_active / T;
  endfunction

  // model: a press is a button seen high two samples ago and low three samples ago
  always @(posedge clk) begin
    if (rst) begin
      m_state = 2'd0;
      m_rstn = 1'b0;
      m_ms = '0;
      m_s = '0;
      m_base += m_active / T;
      m_active = 0;
      h_ss = '1;
      h_lc = '1;
    end else begin
      m_n = m_next();
      if (running_of(m_state) && running_of(m_n)) m_active++;
      m_rstn = !(m_state == 2'd2 && m_n == 2'd0);
      if (!(m_state == 2'd3 && m_n == 2'd3)) begin
        m_ms = sw.mili_segundos;
        m_s = sw.segundos;
      end
      if (m_n == 2'd0) begin
        m_base += m_active / T;
        m_active = 0;
      end
      m_state = m_n;
      h_ss = {h_ss[1:0], sw.btn_start_stop};
      h_lc = {h_lc[1:0], sw.btn_lap_clear};
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (sw.cnt_enable === 1'b1) obs_ticks++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw.btn_start_stop = 1'($urandom);
    sw.btn_lap_clear = 1'($urandom);
    sw.mili_segundos = 10'($urandom);
    sw.segundos = 10'($urandom);
    wait_n(3);
    #1;
    n_cmp++; if (sw.state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", sw.state); end
    n_cmp++; if (sw.cnt_rst_n !== 1'b0) begin n_bad++; $display("FAIL reset_cnt_rst_n: got %b expected 0", sw.cnt_rst_n); end
    n_cmp++; if (sw.cnt_enable !== 1'b0) begin n_bad++; $display("FAIL reset_cnt_enable: got %b expected 0", sw.cnt_enable); end
    n_cmp++; if (sw.disp_ms !== 10'd0 || sw.disp_s !== 10'd0) begin n_bad++; $display("FAIL reset_disp: got %0d/%0d expected 0/0", sw.disp_ms, sw.disp_s); end
    n_cmp++; if (sw.running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b expected 0", sw.running); end
    sw.btn_start_stop = 1'b0;
    sw.btn_lap_clear = 1'b0;
    rst = 1'b0;
    wait_n(1);
    n_cmp++; if (sw.cnt_rst_n !== 1'b1) begin n_bad++; $display("FAIL reset_release_cnt_rst_n: got %b expected 1", sw.cnt_rst_n); end
    n_cmp++; if (sw.state !== 2'd0) begin n_bad++; $display("FAIL reset_release_state: got %0d expected 0", sw.state); end
  endtask

  task automatic test_run_ticks();
    int cnt;
    sw.btn_start_stop = 1'b1;
    wait_n(1);
    sw.btn_start_stop = 1'b0;
    wait_n(1);
    n_cmp++; if (sw.state !== 2'd0) begin n_bad++; $display("FAIL start_latency_early: got %0d expected 0", sw.state); end
    wait_n(1);
    n_cmp++; if (sw.state !== 2'd1) begin n_bad++; $display("FAIL start_latency: got %0d expected 1", sw.state); end
    n_cmp++; if (sw.running !== 1'b1) begin n_bad++; $display("FAIL start_running: got %b expected 1", sw.running); end
    cnt = 0;
    repeat (40) begin
      #1;
      if (sw.cnt_enable === 1'b1) cnt++;
      n_cmp++; if (sw.cnt_enable !== m_en()) begin n_bad++; $display("FAIL run_enable: got %b expected %b", sw.cnt_enable, m_en()); end
      wait_n(1);
    end
    n_cmp++; if (cnt !== 10) begin n_bad++; $display("FAIL run_pulse_count: got %0d expected 10", cnt); end
    n_cmp++; if (obs_ticks !== m_ticks()) begin n_bad++; $display("FAIL run_tick_total: got %0d expected %0d", obs_ticks, m_ticks()); end
  endtask

  task automatic test_pause_resume();
    int k;
    int first_at;
    k = 0;
    while (m_active % T != 0 && k < 2 * T) begin wait_n(1); k++; end
    sw.btn_start_stop = 1'b1;
    wait_n(1);
    sw.btn_start_stop = 1'b0;
    k = 0;
    while (sw.state !== 2'd2 && k < 6) begin wait_n(1); k++; end
    n_cmp++; if (sw.state !== 2'd2) begin n_bad++; $display("FAIL pause_state: got %0d expected 2", sw.state); end
    repeat (6) begin
      #1;
      n_cmp++; if (sw.cnt_enable !== 1'b0) begin n_bad++; $display("FAIL pause_enable: got %b expected 0", sw.cnt_enable); end
      wait_n(1);
    end
    sw.btn_start_stop = 1'b1;
    wait_n(1);
    sw.btn_start_stop = 1'b0;
    k = 0;
    while (sw.state !== 2'd1 && k < 6) begin wait_n(1); k++; end
    n_cmp++; if (sw.state !== 2'd1) begin n_bad++; $display("FAIL resume_state: got %0d expected 1", sw.state); end
    first_at = -1;
    for (int i = 0; i < 2 * T; i++) begin
      #1;
      if (sw.cnt_enable === 1'b1 && first_at < 0) first_at = i;
      wait_n(1);
    end
    // held prescaler value is 2, so one more RUN cycle reaches the wrap
    n_cmp++; if (first_at !== T - 1 - 2) begin n_bad++; $display("FAIL resume_first_tick: got %0d expected %0d", first_at, T - 3); end
  endtask

  task automatic test_lap();
    logic [9:0] x_ms, x_s;
    sw.mili_segundos = 10'd123;
    sw.segundos = 10'd4;
    sw.btn_lap_clear = 1'b1;
    wait_n(1);
    sw.btn_lap_clear = 1'b0;
    wait_n(2);
`ifdef STOPWATCH_LAP_EN
    n_cmp++; if (sw.state !== 2'd3) begin n_bad++; $display("FAIL lap_state: got %0d expected 3", sw.state); end
    n_cmp++; if (sw.running !== 1'b1) begin n_bad++; $display("FAIL lap_running: got %b expected 1", sw.running); end
    repeat (5) begin
      sw.mili_segundos = 10'($urandom_range(124, 999));
      sw.segundos = 10'($urandom_range(5, 99));
      wait_n(1);
      n_cmp++; if (sw.disp_ms !== 10'd123 || sw.disp_s !== 10'd4) begin n_bad++; $display("FAIL lap_freeze: got %0d/%0d expected 123/4", sw.disp_ms, sw.disp_s); end
    end
    sw.btn_lap_clear = 1'b1;
    wait_n(1);
    sw.btn_lap_clear = 1'b0;
    wait_n(2);
    n_cmp++; if (sw.state !== 2'd1) begin n_bad++; $display("FAIL lap_release_state: got %0d expected 1", sw.state); end
`else
    n_cmp++; if (sw.state !== 2'd1) begin n_bad++; $display("FAIL lap_ignored_state: got %0d expected 1", sw.state); end
    n_cmp++; if (sw.disp_ms !== 10'd123 || sw.disp_s !== 10'd4) begin n_bad++; $display("FAIL lap_ignored_disp: got %0d/%0d expected 123/4", sw.disp_ms, sw.disp_s); end
`endif
    x_ms = 10'($urandom);
    x_s = 10'($urandom);
    sw.mili_segundos = x_ms;
    sw.segundos = x_s;
    wait_n(1);
    n_cmp++; if (sw.disp_ms !== x_ms || sw.disp_s !== x_s) begin n_bad++; $display("FAIL disp_track: got %0d/%0d expected %0d/%0d", sw.disp_ms, sw.disp_s, x_ms, x_s); end
  endtask

  task automatic test_clear();
    int k;
    int lows;
    int first_at;
    sw.btn_start_stop = 1'b1;
    wait_n(1);
    sw.btn_start_stop = 1'b0;
    k = 0;
    while (sw.state !== 2'd2 && k < 6) begin wait_n(1); k++; end
    n_cmp++; if (sw.state !== 2'd2) begin n_bad++; $display("FAIL clear_pause_state: got %0d expected 2", sw.state); end
    sw.btn_lap_clear = 1'b1;
    wait_n(1);
    sw.btn_lap_clear = 1'b0;
    lows = 0;
    repeat (6) begin
      if (sw.cnt_rst_n === 1'b0) lows++;
      wait_n(1);
    end
    n_cmp++; if (lows !== 1) begin n_bad++; $display("FAIL clear_pulse_width: got %0d expected 1", lows); end
    n_cmp++; if (sw.state !== 2'd0) begin n_bad++; $display("FAIL clear_state: got %0d expected 0", sw.state); end
    sw.btn_start_stop = 1'b1;
    wait_n(1);
    sw.btn_start_stop = 1'b0;
    k = 0;
    while (sw.state !== 2'd1 && k < 6) begin wait_n(1); k++; end
    first_at = -1;
    for (int i = 0; i < 2 * T; i++) begin
      #1;
      if (sw.cnt_enable === 1'b1 && first_at < 0) first_at = i;
      wait_n(1);
    end
    n_cmp++; if (first_at !== T - 1) begin n_bad++; $display("FAIL clear_prescaler_zero: got %0d expected %0d", first_at, T - 1); end
  endtask

  task automatic test_both();
    logic saw_lap;
    sw.btn_start_stop = 1'b1;
    sw.btn_lap_clear = 1'b1;
    wait_n(1);
    sw.btn_start_stop = 1'b0;
    sw.btn_lap_clear = 1'b0;
    saw_lap = 1'b0;
    repeat (5) begin
      if (sw.state === 2'd3) saw_lap = 1'b1;
      wait_n(1);
    end
    n_cmp++; if (saw_lap !== 1'b0) begin n_bad++; $display("FAIL both_no_lap: got %b expected 0", saw_lap); end
    n_cmp++; if (sw.state !== 2'd2) begin n_bad++; $display("FAIL both_state: got %0d expected 2", sw.state); end
  endtask

  task automatic test_hold_reset();
    sw.btn_start_stop = 1'b1;
    rst = 1'b1;
    wait_n(3);
    rst = 1'b0;
    wait_n(5);
    n_cmp++; if (sw.state !== 2'd0) begin n_bad++; $display("FAIL held_button_state: got %0d expected 0", sw.state); end
    sw.btn_start_stop = 1'b0;
    wait_n(3);
    n_cmp++; if (sw.state !== 2'd0) begin n_bad++; $display("FAIL held_release_state: got %0d expected 0", sw.state); end
    sw.btn_start_stop = 1'b1;
    wait_n(1);
    sw.btn_start_stop = 1'b0;
    wait_n(2);
    n_cmp++; if (sw.state !== 2'd1) begin n_bad++; $display("FAIL held_repress_state: got %0d expected 1", sw.state); end
  endtask

  task automatic test_random();
    repeat (600) begin
      wait_n(1);
      n_cmp++; if (sw.state !== m_state) begin n_bad++; $display("FAIL rand_state: got %0d expected %0d", sw.state, m_state); end
      n_cmp++; if (sw.running !== running_of(m_state)) begin n_bad++; $display("FAIL rand_running: got %b expected %b", sw.running, running_of(m_state)); end
      n_cmp++; if (sw.cnt_rst_n !== m_rstn) begin n_bad++; $display("FAIL rand_cnt_rst_n: got %b expected %b", sw.cnt_rst_n, m_rstn); end
      n_cmp++; if (sw.disp_ms !== m_ms || sw.disp_s !== m_s) begin n_bad++; $display("FAIL rand_disp: got %0d/%0d expected %0d/%0d", sw.disp_ms, sw.disp_s, m_ms, m_s); end
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 5) == 0) sw.btn_start_stop = ~sw.btn_start_stop;
      if ($urandom_range(0, 4) == 0) sw.btn_lap_clear = ~sw.btn_lap_clear;
      sw.mili_segundos = 10'($urandom_range(0, 999));
      sw.segundos = 10'($urandom_range(0, 99));
      #1;
      n_cmp++; if (sw.cnt_enable !== m_en()) begin n_bad++; $display("FAIL rand_enable: got %b expected %b", sw.cnt_enable, m_en()); end
    end
    rst = 1'b0;
    wait_n(1);
    n_cmp++; if (obs_ticks !== m_ticks()) begin n_bad++; $display("FAIL rand_tick_total: got %0d expected %0d", obs_ticks, m_ticks()); end
  endtask

  initial begin
    sw.btn_start_stop = 1'b0;
    sw.btn_lap_clear = 1'b0;
    sw.mili_segundos = '0;
    sw.segundos = '0;
    test_reset();
    test_run_ticks();
    test_pause_resume();
    test_lap();
    test_clear();
    test_both();
    test_hold_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
